hpdmc_cmdsched: RTL and testbench
=================================

Name: hpdmc_cmdsched

Overview:
- Upstream command scheduler for the DDR16 controller's data-timing stage.
- Takes single-burst access requests from the bus interface and manages per-bank open rows: ACTIVATE, PRECHARGE, READ/WRITE, plus periodic PRECHARGE ALL + AUTO REFRESH.
- Drives the SDRAM command/address pins.
- Emits the read/write/concerned_bank pulses the data-timing stage consumes, and obeys its read_safe/write_safe/precharge_safe outputs.

Parameters:
- SDRAM_DEPTH, 26, log2 of SDRAM size in bytes.
- SDRAM_COLUMNDEPTH, 10, log2 of columns per row.
- Row field width RW = SDRAM_DEPTH-SDRAM_COLUMNDEPTH-3 (13 at defaults).

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sdram_rst  in  1  synchronous active-high reset.
- tim_rp  in  3  PRECHARGE-to-next-command spacing parameter.
- tim_rcd  in  3  ACTIVATE-to-READ/WRITE spacing parameter.
- tim_refi  in  11  refresh interval, cycles.
- tim_rfc  in  4  AUTO REFRESH-to-next-command spacing parameter.
- stb  in  1  access request; held until cmd_ack.
- we  in  1  1=write, 0=read; stable while stb.
- address  in  SDRAM_DEPTH-3  burst address {row[RW-1:0], bank[1:0], col[SDRAM_COLUMNDEPTH-3:0]}; stable while stb.
- cmd_ack  out  1  one-cycle pulse: request issued.
- read  out  1  READ issued this cycle.
- write  out  1  WRITE issued this cycle.
- concerned_bank  out  4  one-hot bank of read/write; 0 otherwise.
- read_safe  in  1  from data-timing stage.
- write_safe  in  1  from data-timing stage.
- precharge_safe  in  4  per-bank, from data-timing stage.
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  registered command.
- sdram_ba  out  2  bank address.
- sdram_adr  out  13  row/column address.

Behaviour:
- All outputs registered.
- Reset values:
  - cs_n/ras_n/cas_n/we_n=1; ba=0; adr=0.
  - read=write=cmd_ack=0; concerned_bank=0.
  - All banks closed; refresh_pending=0; refresh counter=tim_refi; FSM=IDLE.
- Any cycle without a command: NOP (cs_n=0, ras_n=cas_n=we_n=1).
- Reset mid-operation aborts everything; an unacked stb stays unacked.
- Per-bank state: has_openrow[3:0], openrow[b][RW-1:0].
- Refresh counter:
  - Decrements every cycle.
  - At 0: sets refresh_pending, reloads tim_refi.
  - refresh_pending clears on AUTO REFRESH issue.
  - A counter expiry while pending is already set is absorbed (stays 1).
- FSM states: IDLE, TRP_WAIT, ACT_WAIT, PREALL_WAIT, REF_WAIT.
- IDLE priority: refresh_pending first, then stb.
- Refresh, some bank open:
  - Requires precharge_safe==4'hF; else NOP.
  - Issue PRECHARGE ALL (ras_n=0, we_n=0, adr[10]=1); clear all has_openrow; go to PREALL_WAIT.
- Refresh, all banks closed:
  - Issue AUTO REFRESH (ras_n=0, cas_n=0); go to REF_WAIT.
- Refresh pre-empts a pending stb, including a row hit.
- Request, bank b = address bank field:
  - Row hit (has_openrow[b], openrow[b]==row):
    - Issue when (we & write_safe) | (~we & read_safe); else NOP.
    - READ/WRITE: cas_n=0, we_n=~we, ba=b, adr={0.., col, 2'b00}, adr[10]=0 (no auto-precharge).
    - Same edge: read or write=1, concerned_bank=1<<b, cmd_ack=1.
  - Row miss (has_openrow[b], row differs):
    - Requires precharge_safe[b]; else NOP.
    - PRECHARGE (ras_n=0, we_n=0, adr[10]=0, ba=b); clear has_openrow[b]; go to TRP_WAIT.
  - Bank closed:
    - ACTIVATE (ras_n=0, ba=b, adr=row); set has_openrow[b]; openrow[b]=row; go to ACT_WAIT.
- Wait states:
  - A counter loads the timing value on the command edge and decrements each cycle.
  - The next command issues no earlier than tim_x+1 cycles after the previous command edge.
  - Exits: TRP_WAIT->IDLE; PREALL_WAIT->AUTO REFRESH->REF_WAIT; ACT_WAIT->IDLE; REF_WAIT->IDLE.
- From IDLE after a miss: ACTIVATE follows, then the row-hit READ/WRITE.
- read and write never both high; cmd_ack exactly once per request.
- Back-to-back hits may issue on consecutive cycles, gated only by read_safe/write_safe.
- Timing inputs sampled at load time; changing them mid-wait does not affect the running count.

Test Plan:
- Reset, then idle 20 cycles with tim_refi=1000 -> all pins NOP (cs_n=0, ras/cas/we_n=1); read=write=cmd_ack=0.
- Read to closed bank 2, row 0x123, col 5, tim_rcd=2 -> ACTIVATE ba=2 adr=0x123 at t; READ at t+3 with adr=0x014; read=1, concerned_bank=4'b0100, cmd_ack=1 same cycle.
- Write to bank 2 row 0x124 after above, precharge_safe[2]=0 for 4 cycles, tim_rp=1 -> NOPs while unsafe; PRECHARGE ba=2 adr[10]=0; ACTIVATE 2 cycles later; WRITE 3 cycles after that (tim_rcd=2); write=1.
- Two row hits, second a write with write_safe low 3 cycles -> first read acked; write waits 3 NOP cycles, then WRITE plus cmd_ack.
- tim_refi=50, bank 0 open, stb pending hit when refresh fires -> PRECHARGE ALL (adr[10]=1), AUTO REFRESH after tim_rp+1, access later re-ACTIVATEs bank 0 before the READ.
- Assert sdram_rst during ACT_WAIT -> next cycle all outputs at reset values, all banks closed; request is re-ACTIVATEd after reset release.

Source files
------------

// File: rtl/hpdmc_cmdsched.sv
// SDRAM command scheduler: tracks per-bank open rows and sequences
// ACTIVATE / PRECHARGE / READ / WRITE plus periodic PRECHARGE ALL + AUTO REFRESH.
module hpdmc_cmdsched #(
  parameter int SDRAM_DEPTH       = 26,
  parameter int SDRAM_COLUMNDEPTH = 10
) (
  input  logic                   sys_clk,
  input  logic                   sdram_rst,
  input  logic [2:0]             tim_rp,
  input  logic [2:0]             tim_rcd,
  input  logic [10:0]            tim_refi,
  input  logic [3:0]             tim_rfc,
  input  logic                   stb,
  input  logic                   we,
  input  logic [SDRAM_DEPTH-4:0] address,
  output logic                   cmd_ack,
  output logic                   read,
  output logic                   write,
  output logic [3:0]             concerned_bank,
  input  logic                   read_safe,
  input  logic                   write_safe,
  input  logic [3:0]             precharge_safe,
  output logic                   sdram_cs_n,
  output logic                   sdram_ras_n,
  output logic                   sdram_cas_n,
  output logic                   sdram_we_n,
  output logic [1:0]             sdram_ba,
  output logic [12:0]            sdram_adr
);
  localparam int RW = SDRAM_DEPTH - SDRAM_COLUMNDEPTH - 3;
  localparam int CW = SDRAM_COLUMNDEPTH - 2;

  localparam logic [3:0] CMD_RESET = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;

  typedef enum logic [2:0] {IDLE, TRP_WAIT, ACT_WAIT, PREALL_WAIT, REF_WAIT} state_t;

  state_t         state;
  logic [3:0]     has_openrow;
  logic [RW-1:0]  openrow [4];
  logic           refresh_pending;
  logic [10:0]    refresh_cnt;
  logic [3:0]     wait_cnt;

  logic [CW-1:0]  col;
  logic [1:0]     bank;
  logic [RW-1:0]  row;
  logic           row_hit;
  logic           data_safe;

  assign col       = address[CW-1:0];
  assign bank      = address[CW+1:CW];
  assign row       = address[SDRAM_DEPTH-4:CW+2];
  assign row_hit   = has_openrow[bank] && (openrow[bank] == row);
  assign data_safe = we ? write_safe : read_safe;

  always_ff @(posedge sys_clk) begin
    if (sdram_rst) begin
      state           <= IDLE;
      has_openrow     <= '0;
      refresh_pending <= 1'b0;
      refresh_cnt     <= tim_refi;
      wait_cnt        <= '0;
      {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= CMD_RESET;
      sdram_ba        <= '0;
      sdram_adr       <= '0;
      cmd_ack         <= 1'b0;
      read            <= 1'b0;
      write           <= 1'b0;
      concerned_bank  <= '0;
    end else begin
      {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= CMD_NOP;
      cmd_ack        <= 1'b0;
      read           <= 1'b0;
      write          <= 1'b0;
      concerned_bank <= '0;

      case (state)
        IDLE: begin
          if (refresh_pending) begin
            if (|has_openrow) begin
              if (&precharge_safe) begin
                {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= CMD_PRE;
                sdram_adr   <= 13'h400;
                has_openrow <= '0;
                wait_cnt    <= {1'b0, tim_rp};
                state       <= PREALL_WAIT;
              end
            end else begin
              {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= CMD_REF;
              refresh_pending <= 1'b0;
              wait_cnt        <= tim_rfc;
              state           <= (tim_rfc == 4'd0) ? IDLE : REF_WAIT;
            end
          end else if (stb) begin
            if (row_hit) begin
              if (data_safe) begin
                {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= we ? CMD_WRITE : CMD_READ;
                sdram_ba       <= bank;
                sdram_adr      <= 13'({col, 2'b00});
                read           <= ~we;
                write          <= we;
                concerned_bank <= 4'b0001 << bank;
                cmd_ack        <= 1'b1;
              end
            end else if (has_openrow[bank]) begin
              if (precharge_safe[bank]) begin
                {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= CMD_PRE;
                sdram_ba          <= bank;
                sdram_adr         <= '0;
                has_openrow[bank] <= 1'b0;
                wait_cnt          <= {1'b0, tim_rp};
                state             <= (tim_rp == 3'd0) ? IDLE : TRP_WAIT;
              end
            end else begin
              {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= CMD_ACT;
              sdram_ba          <= bank;
              sdram_adr         <= 13'(row);
              has_openrow[bank] <= 1'b1;
              openrow[bank]     <= row;
              wait_cnt          <= {1'b0, tim_rcd};
              state             <= (tim_rcd == 3'd0) ? IDLE : ACT_WAIT;
            end
          end
        end
        PREALL_WAIT: begin
          // AUTO REFRESH issues straight from here, so it fires at count zero
          if (wait_cnt == 4'd0) begin
            {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= CMD_REF;
            refresh_pending <= 1'b0;
            wait_cnt        <= tim_rfc;
            state           <= (tim_rfc == 4'd0) ? IDLE : REF_WAIT;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: begin
          // leave one cycle early: IDLE itself spends the final cycle of the spacing
          if (wait_cnt <= 4'd1) state <= IDLE;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
      endcase

      // expiry wins over a same-cycle refresh issue; a repeat expiry is absorbed
      if (refresh_cnt == 11'd0) begin
        refresh_pending <= 1'b1;
        refresh_cnt     <= tim_refi;
      end else begin
        refresh_cnt <= refresh_cnt - 11'd1;
      end
    end
  end
endmodule

// File: tb/tb_hpdmc_cmdsched.sv
// Bench for hpdmc_cmdsched: directed scenarios plus a randomized run, every
// cycle compared against a timestamp-based reference model.
module tb_hpdmc_cmdsched;
  logic        sys_clk = 1'b0;
  logic        sdram_rst;
  logic [2:0]  tim_rp, tim_rcd;
  logic [10:0] tim_refi;
  logic [3:0]  tim_rfc;
  logic        stb, we;
  logic [22:0] address;
  logic        cmd_ack, read, write;
  logic [3:0]  concerned_bank;
  logic        read_safe, write_safe;
  logic [3:0]  precharge_safe;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_adr;
  logic [3:0]  dut_cmd;

  always #5 sys_clk = ~sys_clk;

  hpdmc_cmdsched dut (
    .sys_clk(sys_clk), .sdram_rst(sdram_rst),
    .tim_rp(tim_rp), .tim_rcd(tim_rcd), .tim_refi(tim_refi), .tim_rfc(tim_rfc),
    .stb(stb), .we(we), .address(address),
    .cmd_ack(cmd_ack), .read(read), .write(write), .concerned_bank(concerned_bank),
    .read_safe(read_safe), .write_safe(write_safe), .precharge_safe(precharge_safe),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n),
    .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba), .sdram_adr(sdram_adr)
  );

  assign dut_cmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};

  localparam logic [3:0] C_RST = 4'b1111, C_NOP = 4'b0111, C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101, C_WR  = 4'b0100, C_PRE = 4'b0010, C_REF = 4'b0001;

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;

  // reference model: open rows plus absolute edge numbers for spacing and refresh
  bit          m_open [4];
  logic [12:0] m_row  [4];
  int unsigned m_free, m_ar_at, m_next_exp;
  bit          m_ar_due, m_pend;

  logic [3:0]  e_cmd, e_cb;
  logic [1:0]  e_ba;
  logic [12:0] e_adr, e_mask;
  logic        e_rd, e_wr, e_ack, e_chk_ba;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [22:0] mk(input logic [12:0] r, input logic [1:0] b, input logic [7:0] c);
    return {r, b, c};
  endfunction

  task automatic model_edge();
    logic [1:0]  b;
    logic [12:0] r;
    logic [7:0]  c;
    bit          ar_now;
    cyc++;
    e_rd = 0; e_wr = 0; e_ack = 0; e_cb = '0; e_cmd = C_NOP;
    e_chk_ba = 0; e_ba = '0; e_adr = '0; e_mask = '0; ar_now = 0;
    if (sdram_rst) begin
      e_cmd = C_RST; e_chk_ba = 1; e_mask = '1;
      for (int i = 0; i < 4; i++) m_open[i] = 0;
      m_pend = 0; m_ar_due = 0; m_free = 0;
      m_next_exp = cyc + 32'(tim_refi) + 1;
      return;
    end
    r = address[22:10]; b = address[9:8]; c = address[7:0];
    if (m_ar_due) begin
      if (cyc == m_ar_at) begin
        e_cmd = C_REF; ar_now = 1; m_ar_due = 0;
        m_free = cyc + 32'(tim_rfc) + 1;
      end
    end else if (cyc >= m_free) begin
      if (m_pend) begin
        if (m_open[0] || m_open[1] || m_open[2] || m_open[3]) begin
          if (precharge_safe == 4'hF) begin
            e_cmd = C_PRE; e_adr = 13'h400; e_mask = 13'h400;
            for (int i = 0; i < 4; i++) m_open[i] = 0;
            m_ar_due = 1; m_ar_at = cyc + 32'(tim_rp) + 1;
          end
        end else begin
          e_cmd = C_REF; ar_now = 1;
          m_free = cyc + 32'(tim_rfc) + 1;
        end
      end else if (stb) begin
        if (m_open[b] && m_row[b] == r) begin
          if (we ? write_safe : read_safe) begin
            e_cmd = we ? C_WR : C_RD; e_chk_ba = 1; e_ba = b;
            e_adr = {3'b000, c, 2'b00}; e_mask = '1;
            e_rd = ~we; e_wr = we; e_cb = 4'b0001 << b; e_ack = 1;
          end
        end else if (m_open[b]) begin
          if (precharge_safe[b]) begin
            e_cmd = C_PRE; e_chk_ba = 1; e_ba = b; e_mask = 13'h400;
            m_open[b] = 0; m_free = cyc + 32'(tim_rp) + 1;
          end
        end else begin
          e_cmd = C_ACT; e_chk_ba = 1; e_ba = b; e_adr = r; e_mask = '1;
          m_open[b] = 1; m_row[b] = r; m_free = cyc + 32'(tim_rcd) + 1;
        end
      end
    end
    if (ar_now) m_pend = 0;
    if (cyc == m_next_exp) begin
      m_pend = 1;
      m_next_exp = cyc + 32'(tim_refi) + 1;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge sys_clk);
    #1;
    chk("cmd", 32'(dut_cmd), 32'(e_cmd));
    chk("flags", 32'({read, write, cmd_ack, concerned_bank}), 32'({e_rd, e_wr, e_ack, e_cb}));
    if (e_chk_ba) chk("ba", 32'(sdram_ba), 32'(e_ba));
    if (e_mask != '0) chk("adr", 32'(sdram_adr & e_mask), 32'(e_adr & e_mask));
  endtask

  task automatic wait_cmd(input int maxc, output bit seen);
    seen = 0;
    for (int i = 0; i < maxc && !seen; i++) begin
      step();
      if (dut_cmd != C_NOP) seen = 1;
    end
  endtask

  initial begin
    bit seen;
    sdram_rst = 1; tim_rp = 3'd1; tim_rcd = 3'd2; tim_refi = 11'd1000; tim_rfc = 4'd3;
    stb = 0; we = 0; address = '0;
    read_safe = 1; write_safe = 1; precharge_safe = 4'hF;
    step(); step();
    chk("rst_pins", 32'({dut_cmd, sdram_ba, sdram_adr}), 32'({C_RST, 2'd0, 13'd0}));
    sdram_rst = 0;

    // idle: NOP every cycle
    repeat (20) step();
    chk("idle_nop", 32'({dut_cmd, read, write, cmd_ack}), 32'({C_NOP, 3'b000}));

    // read to closed bank 2
    address = mk(13'h123, 2'd2, 8'd5); we = 0; stb = 1;
    step();
    chk("t2_act", 32'({dut_cmd, sdram_ba, sdram_adr}), 32'({C_ACT, 2'd2, 13'h123}));
    repeat (3) step();
    chk("t2_rd", 32'({dut_cmd, sdram_adr, read, concerned_bank, cmd_ack}),
        32'({C_RD, 13'h014, 1'b1, 4'b0100, 1'b1}));
    stb = 0;

    // row miss with bank 2 not yet safe to precharge
    address = mk(13'h124, 2'd2, 8'd7); we = 1; stb = 1; precharge_safe = 4'b1011;
    repeat (4) step();
    chk("t3_hold", 32'(dut_cmd), 32'(C_NOP));
    precharge_safe = 4'hF;
    step();
    chk("t3_pre", 32'({dut_cmd, sdram_ba, sdram_adr[10]}), 32'({C_PRE, 2'd2, 1'b0}));
    repeat (2) step();
    chk("t3_act", 32'({dut_cmd, sdram_ba, sdram_adr}), 32'({C_ACT, 2'd2, 13'h124}));
    repeat (3) step();
    chk("t3_wr", 32'({dut_cmd, write, read, cmd_ack}), 32'({C_WR, 1'b1, 1'b0, 1'b1}));
    stb = 0;

    // two hits, the write held off by write_safe
    address = mk(13'h124, 2'd2, 8'd1); we = 0; stb = 1; write_safe = 0;
    step();
    chk("t4_rd", 32'({dut_cmd, cmd_ack}), 32'({C_RD, 1'b1}));
    address = mk(13'h124, 2'd2, 8'd2); we = 1;
    repeat (3) step();
    chk("t4_hold", 32'({dut_cmd, cmd_ack}), 32'({C_NOP, 1'b0}));
    write_safe = 1;
    step();
    chk("t4_wr", 32'({dut_cmd, write, cmd_ack, sdram_adr}), 32'({C_WR, 1'b1, 1'b1, 13'h008}));
    stb = 0;

    // refresh pre-empts a pending row hit
    tim_refi = 11'd50; sdram_rst = 1; step(); sdram_rst = 0;
    address = mk(13'h010, 2'd0, 8'd3); we = 0; stb = 1;
    wait_cmd(10, seen);
    chk("t5_act0", 32'({seen, dut_cmd}), 32'({1'b1, C_ACT}));
    wait_cmd(10, seen);
    chk("t5_rd0", 32'({seen, dut_cmd, cmd_ack}), 32'({1'b1, C_RD, 1'b1}));
    read_safe = 0;
    wait_cmd(80, seen);
    chk("t5_preall", 32'({seen, dut_cmd, sdram_adr[10]}), 32'({1'b1, C_PRE, 1'b1}));
    read_safe = 1;
    repeat (2) step();
    chk("t5_ref", 32'(dut_cmd), 32'(C_REF));
    wait_cmd(10, seen);
    chk("t5_react", 32'({seen, dut_cmd, sdram_ba}), 32'({1'b1, C_ACT, 2'd0}));
    wait_cmd(10, seen);
    chk("t5_rd1", 32'({seen, dut_cmd, cmd_ack}), 32'({1'b1, C_RD, 1'b1}));
    stb = 0;

    // reset in ACT_WAIT: the request must be re-activated afterwards
    tim_rcd = 3'd3; tim_refi = 11'd1000;
    address = mk(13'h077, 2'd3, 8'd9); we = 0; stb = 1;
    step();
    chk("t6_act", 32'({dut_cmd, sdram_ba}), 32'({C_ACT, 2'd3}));
    step();
    sdram_rst = 1;
    step();
    chk("t6_rst", 32'({dut_cmd, sdram_ba, sdram_adr, read, write, cmd_ack, concerned_bank}),
        32'({C_RST, 2'd0, 13'd0, 3'b000, 4'd0}));
    sdram_rst = 0;
    step();
    chk("t6_react", 32'({dut_cmd, sdram_ba, sdram_adr}), 32'({C_ACT, 2'd3, 13'h077}));
    wait_cmd(10, seen);
    chk("t6_rd", 32'({seen, dut_cmd, cmd_ack}), 32'({1'b1, C_RD, 1'b1}));
    stb = 0;

    // randomized traffic; timing inputs change every cycle to exercise load-time sampling
    for (int n = 0; n < 3000; n++) begin
      if (!stb || e_ack) begin
        stb = ($urandom_range(0, 2) != 0);
        we  = $urandom_range(0, 1) == 1;
        case ($urandom_range(0, 3))
          0:       address = mk(13'h010, 2'($urandom_range(0, 3)), 8'($urandom));
          1:       address = mk(13'h011, 2'($urandom_range(0, 3)), 8'($urandom));
          2:       address = mk(13'h1FFF, 2'($urandom_range(0, 3)), 8'($urandom));
          default: address = mk(13'($urandom), 2'($urandom_range(0, 3)), 8'($urandom));
        endcase
      end
      read_safe      = $urandom_range(0, 3) != 0;
      write_safe     = $urandom_range(0, 3) != 0;
      for (int i = 0; i < 4; i++) precharge_safe[i] = $urandom_range(0, 4) != 0;
      tim_rp         = 3'($urandom_range(0, 3));
      tim_rcd        = 3'($urandom_range(0, 3));
      tim_rfc        = 4'($urandom_range(0, 5));
      tim_refi       = 11'($urandom_range(20, 60));
      sdram_rst      = $urandom_range(0, 299) == 0;
      step();
    end
    sdram_rst = 0; stb = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
